// File: rtl/popcount_pkg.sv
// ============================================================================
//  popcount_pkg : shared state encoding and chunk width for popcount_sequencer
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package popcount_pkg;

  localparam int CHUNK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/byte_popcount.sv
// ============================================================================
//  byte_popcount : combinational count of set bits in one 8-bit chunk
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module byte_popcount
  import popcount_pkg::*;
(
  input  logic [CHUNK_W-1:0] data,
  output logic [3:0]         count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      count = count + {3'b000, data[i]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/popcount_sequencer.sv
// ============================================================================
//  popcount_sequencer : multi-cycle population count, one byte chunk per cycle
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module popcount_sequencer
  import popcount_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         abort,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DATA_W+1)-1:0]  out_count,
  output logic                         busy
);

  localparam int N_CHUNK = DATA_W / CHUNK_W;
  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam int IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNK - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  w_shift_nxt;
  logic [CNT_W-1:0]   r_acc;
  logic [CNT_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               r_out_valid;
  logic               w_out_valid_nxt;
  logic [3:0]         w_chunk_cnt;
  logic [CNT_W-1:0]   w_acc_sum;

  byte_popcount u_byte_popcount (
    .data  (r_shift[CHUNK_W-1:0]),
    .count (w_chunk_cnt)
  );

  assign w_acc_sum = r_acc + CNT_W'(w_chunk_cnt);

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_acc_nxt       = r_acc;
    w_count_nxt     = r_count;
    w_idx_nxt       = r_idx;
    w_out_valid_nxt = r_out_valid;

    // abort outranks every other transition; in IDLE it only blocks acceptance
    if (abort) begin
      if (r_state != ST_IDLE) begin
        w_state_nxt     = ST_IDLE;
        w_acc_nxt       = '0;
        w_idx_nxt       = '0;
        w_count_nxt     = '0;
        w_out_valid_nxt = 1'b0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            w_shift_nxt = in_data;
            w_acc_nxt   = '0;
            w_idx_nxt   = '0;
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          w_acc_nxt   = w_acc_sum;
          w_shift_nxt = r_shift >> CHUNK_W;
          w_idx_nxt   = r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) begin
            w_count_nxt     = w_acc_sum;
            w_out_valid_nxt = 1'b1;
            w_idx_nxt       = '0;
            w_state_nxt     = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_acc       <= '0;
      r_count     <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_shift     <= w_shift_nxt;
      r_acc       <= w_acc_nxt;
      r_count     <= w_count_nxt;
      r_idx       <= w_idx_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = r_out_valid;
  assign out_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_popcount_sequencer.sv
// ============================================================================
//  tb_popcount_sequencer : self-checking bench for popcount_sequencer (DATA_W=32)
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_popcount_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_count;
  logic        busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] data;
    int          hold;
    int          exp;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  popcount_sequencer #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  function automatic int ref_count(logic [31:0] w);
    int n = 0;
    for (int i = 0; i < 32; i++) begin
      if (w[i]) n++;
    end
    return n;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Present a word, wait (bounded) for in_ready, and let one edge accept it.
  task automatic accept_word(input logic [31:0] data, input bit keep_valid, input string name);
    int guard = 0;
    in_data  = data;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({name, "_ready_wait"}, int'(in_ready), 1);
    @(posedge clk); #1;
    in_data = $urandom;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic run_word(input logic [31:0] data, input int exp, input int hold,
                          input bit keep_valid, input string name);
    int lat    = 0;
    int busy_bad = 0;
    int hold_bad = 0;
    accept_word(data, keep_valid, name);
    while (!out_valid && lat < 20) begin
      if (in_ready || !busy) busy_bad++;
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    out_ready = 1'b0;
    check({name, "_latency"}, lat, 4);
    check({name, "_count"}, int'(out_count), exp);
    check({name, "_busy_while_run"}, busy_bad, 0);
    repeat (hold) begin
      @(posedge clk); #1;
      if (!out_valid || int'(out_count) != exp || in_ready || !busy) hold_bad++;
    end
    check({name, "_hold_stable"}, hold_bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_released"}, int'({out_valid, in_ready}), 1);
  endtask

  initial begin
    int quiet_bad;
    logic [31:0] w;

    vecs[0] = '{32'h0000_0000, 0, 0};
    vecs[1] = '{32'hFFFF_FFFF, 1, 32};
    vecs[2] = '{32'h8000_0001, 0, 2};
    vecs[3] = '{32'h0F0F_00F0, 2, 12};
    vecs[4] = '{32'hA5A5_A5A5, 0, 16};
    vecs[5] = '{32'h1234_5678, 3, 13};
    vecs[6] = '{32'h0000_0003, 0, 2};
    vecs[7] = '{32'h0000_0080, 1, 1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; abort = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_count", int'(out_count), 0);
    check("reset_busy", int'(busy), 0);

    run_word(32'h0000_0000, 0, 0, 1'b0, "zero_word");

    run_word(32'hFFFF_FFFF, 32, 0, 1'b1, "b2b_ones");
    run_word(32'h8000_0001, 2, 0, 1'b1, "b2b_ends");
    run_word(32'h0F0F_00F0, 12, 0, 1'b0, "b2b_nibbles");

    run_word(32'hA5A5_A5A5, 16, 5, 1'b0, "stall_a5");

    for (int i = 0; i < 8; i++) begin
      run_word(vecs[i].data, vecs[i].exp, vecs[i].hold, 1'b0, $sformatf("vec%0d", i));
    end

    // abort in the second RUN cycle
    accept_word(32'h1234_5678, 1'b0, "abort_run");
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_run_idle", int'({in_ready, busy, out_valid}), 4);
    check("abort_run_count", int'(out_count), 0);
    quiet_bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) quiet_bad++;
    end
    check("abort_run_no_result", quiet_bad, 0);
    run_word(32'h0000_0003, 2, 0, 1'b0, "after_abort");

    // abort in IDLE blocks acceptance
    in_data = 32'hFFFF_FFFF; in_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    check("abort_idle_no_accept", int'({in_ready, busy}), 2);

    // abort in DONE clears the pending result
    accept_word(32'h0000_00FF, 1'b0, "abort_done");
    repeat (4) @(posedge clk);
    #1;
    check("abort_done_valid", int'(out_valid), 1);
    check("abort_done_count_before", int'(out_count), 8);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_done_cleared", int'({out_valid, in_ready}), 1);
    check("abort_done_count", int'(out_count), 0);

    // asynchronous reset between edges during RUN
    accept_word(32'hFFFF_0000, 1'b0, "mid_reset");
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ready_busy", int'({in_ready, busy}), 2);
    check("async_reset_valid_count", int'({out_valid, out_count}), 0);
    #1 rst_n = 1'b1;
    quiet_bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid || busy) quiet_bad++;
    end
    check("async_reset_no_result", quiet_bad, 0);
    run_word(32'h0101_0101, 4, 0, 1'b0, "after_reset");

    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      if (i % 10 == 0) w = 32'hFFFF_FFFF ^ (32'h1 << (i % 32));
      run_word(w, ref_count(w), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               $sformatf("rand%0d", i));
    end
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
